hamming_tx: RTL and testbench

- Serial transmitter and encoder for the team's Hamming (7,4)+overall-parity link. It is the transmit-side counterpart of the decoder, syndrome and display-mux path.
- Accepts a 4-bit data nibble over a valid/ready handshake and builds the 8-bit codeword.
- Optionally flips one codeword bit so the receive side can be exercised.
- Sends the codeword over a single-wire UART-style frame: start bit, 8 codeword bits LSB-first, stop bit.

---
 rtl/hamming_tx.sv | 118 +++++++++++
 tb/tb_hamming_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hamming_tx.sv
// Hamming (7,4)+overall-parity encoder with optional single-bit error injection,
// serialized as a UART-style frame: start bit, 8 codeword bits LSB-first, stop bit.
module hamming_tx #(
  parameter int CLKS_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dato,
  input  logic       valido,
  output logic       listo,
  input  logic       err_en,
  input  logic [2:0] err_pos,
  output logic [7:0] palabra,
  output logic       tx,
  output logic       ocupado,
  output logic       hecho
);

  localparam int CNT_W = (CLKS_BIT > 1) ? $clog2(CLKS_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATOS, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       cw;
  logic [7:0]       cw_inj;

  // Bit index equals Hamming position; bit 0 is overall parity, taken before injection.
  always_comb begin
    cw    = '0;
    cw[3] = dato[3];
    cw[5] = dato[2];
    cw[6] = dato[1];
    cw[7] = dato[0];
    cw[1] = cw[3] ^ cw[5] ^ cw[7];
    cw[2] = cw[3] ^ cw[6] ^ cw[7];
    cw[4] = cw[5] ^ cw[6] ^ cw[7];
    cw[0] = ^cw[7:1];
    cw_inj = cw;
    if (err_en) cw_inj[err_pos] = ~cw[err_pos];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      palabra <= '0;
      tx      <= 1'b1;
      listo   <= 1'b1;
      ocupado <= 1'b0;
      hecho   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          hecho <= 1'b0;
          if (valido) begin
            palabra <= cw_inj;
            state   <= START;
            cnt     <= '0;
            idx     <= '0;
            tx      <= 1'b0;
            listo   <= 1'b0;
            ocupado <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATOS;
            tx    <= palabra[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATOS: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              idx   <= '0;
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              tx  <= palabra[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= IDLE;
            hecho   <= 1'b1;
            listo   <= 1'b1;
            ocupado <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          idx     <= '0;
          tx      <= 1'b1;
          listo   <= 1'b1;
          ocupado <= 1'b0;
          hecho   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_tx.sv
// Table-driven bench for hamming_tx with CLKS_BIT=4 plus busy/back-to-back and mid-frame reset sequences.
module tb_hamming_tx;

  localparam int CB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dato = 4'h0;
  logic       valido = 1'b0;
  logic       listo;
  logic       err_en = 1'b0;
  logic [2:0] err_pos = 3'd0;
  logic [7:0] palabra;
  logic       tx;
  logic       ocupado;
  logic       hecho;

  int tests = 0;
  int failed = 0;

  hamming_tx #(.CLKS_BIT(CB)) dut (
    .clk(clk), .rst_n(rst_n), .dato(dato), .valido(valido), .listo(listo),
    .err_en(err_en), .err_pos(err_pos), .palabra(palabra), .tx(tx),
    .ocupado(ocupado), .hecho(hecho)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       en;
    logic [2:0] pos;
    logic [7:0] word;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a nibble at a falling edge; returns just after the transfer edge.
  task automatic start_xfer(input logic [3:0] d, input logic en, input logic [2:0] pos);
    @(negedge clk);
    dato = d; err_en = en; err_pos = pos; valido = 1'b1;
    @(posedge clk);
  endtask

  // Follows the 40 frame cycles after a transfer edge, then the hecho cycle.
  task automatic check_frame(input logic [7:0] word, input bit busy_poke);
    logic exp_bit;
    int j;
    for (int k = 0; k < 10 * CB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("palabra", palabra, word);
        valido = 1'b0;
        dato = ~dato;
        err_en = ~err_en;
        err_pos = err_pos + 3'd3;
      end
      if (busy_poke && k == 2 * CB) begin
        valido = 1'b1; dato = 4'b0000; err_en = 1'b0; err_pos = 3'd0;
      end
      if (k % CB == CB / 2) begin
        j = k / CB;
        exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : word[j-1];
        check($sformatf("tx_bit%0d", j), tx, exp_bit);
        check($sformatf("busy_flags_bit%0d", j), {ocupado, listo, hecho}, 3'b100);
      end
    end
    @(negedge clk);
    check("hecho_cycle", {hecho, listo, ocupado, tx}, 4'b1101);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 1'b0, 3'd0, 8'hCC};
    vecs[1] = '{4'b0000, 1'b0, 3'd0, 8'h00};
    vecs[2] = '{4'b1111, 1'b0, 3'd0, 8'hFF};
    vecs[3] = '{4'b1011, 1'b1, 3'd5, 8'hEC};
    vecs[4] = '{4'b1011, 1'b1, 3'd0, 8'hCD};
    vecs[5] = '{4'b1011, 1'b1, 3'd7, 8'h4C};
    vecs[6] = '{4'b0001, 1'b0, 3'd0, 8'h96};
    vecs[7] = '{4'b1000, 1'b0, 3'd0, 8'h0F};

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset", {tx, ocupado, hecho, palabra}, {1'b1, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), {tx, listo, ocupado, hecho, palabra},
            {1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    end

    // Table of encodings, each sent as a full frame
    for (int v = 0; v < 8; v++) begin
      start_xfer(vecs[v].d, vecs[v].en, vecs[v].pos);
      check_frame(vecs[v].word, 1'b0);
      @(negedge clk);
      check($sformatf("after_hecho_v%0d", v), {hecho, listo, ocupado, tx}, 4'b0101);
    end

    // valido during DATOS is ignored; held valido starts a new frame in the hecho cycle
    start_xfer(4'b1011, 1'b0, 3'd0);
    check_frame(8'hCC, 1'b1);
    check_frame(8'h00, 1'b0);
    @(negedge clk);
    check("b2b_end", {hecho, listo, ocupado}, 3'b010);

    // Reset during DATOS bit 4 (frame bit 5)
    start_xfer(4'b1011, 1'b0, 3'd0);
    for (int k = 0; k <= 5 * CB + CB / 2; k++) begin
      @(negedge clk);
      if (k == 0) valido = 1'b0;
    end
    check("pre_reset_tx", {tx, ocupado}, {1'b0, 1'b1});
    rst_n = 1'b0;
    #1;
    check("async_reset", {tx, ocupado, hecho, listo, palabra}, {1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_xfer(4'b1111, 1'b0, 3'd0);
    check_frame(8'hFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
